// File: rtl/firebird7_in_gate1_tdr_host_pkg.sv
// Shared types and defaults for the firebird7_in gate1 IJTAG TDR host.
package firebird7_in_gate1_tdr_host_pkg;

  localparam int unsigned DefaultMaxLen = 32;

  typedef enum logic [2:0] {
    StIdle,
    StCapture,
    StShift,
    StUpdate,
    StResp
  } tdr_host_state_e;

endpackage

// File: rtl/firebird7_in_gate1_tdr_host_shifter.sv
// Shift datapath: bit counter, write-data holding register and read-data
// collection register for one Capture-Shift-Update access.
module firebird7_in_gate1_tdr_host_shifter
  import firebird7_in_gate1_tdr_host_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefaultMaxLen,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               load_i,
  input  logic [MAX_LEN-1:0] wdata_i,
  input  logic               shift_i,
  input  logic               so_i,
  input  logic [LEN_W-1:0]   len_i,
  output logic               last_o,
  output logic               si_next_o,
  output logic [MAX_LEN-1:0] rdata_o
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [MAX_LEN-1:0] wdata_q, wdata_d;
  logic [MAX_LEN-1:0] rdata_q, rdata_d;

  always_comb begin
    cnt_d   = cnt_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (load_i) begin
      cnt_d   = '0;
      wdata_d = wdata_i;
      rdata_d = '0;
    end else if (shift_i) begin
      if (cnt_q < LEN_W'(MAX_LEN)) begin
        rdata_d[cnt_q[IdxW-1:0]] = so_i;
      end
      cnt_d = cnt_q + LEN_W'(1);
    end
  end

  // Look ahead to the bit that will be presented in the next cycle, since si is registered.
  assign si_next_o = (cnt_d < LEN_W'(MAX_LEN)) ? wdata_d[cnt_d[IdxW-1:0]] : 1'b0;
  assign last_o    = (cnt_q == (len_i - LEN_W'(1)));
  assign rdata_o   = rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

endmodule

// File: rtl/firebird7_in_gate1_tessent_tdr_host.sv
// IJTAG host access engine: turns a parallel request into a Capture-Shift-Update
// sequence on the client strobes and returns the serially collected data.
module firebird7_in_gate1_tessent_tdr_host
  import firebird7_in_gate1_tdr_host_pkg::*;
#(
  parameter int unsigned MAX_LEN = DefaultMaxLen,
  parameter int unsigned LEN_W   = $clog2(MAX_LEN + 1)
) (
  input  logic               ijtag_tck,
  input  logic               ijtag_reset,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [LEN_W-1:0]   req_len,
  input  logic               req_capture,
  input  logic               req_update,
  input  logic [MAX_LEN-1:0] req_wdata,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [MAX_LEN-1:0] rsp_rdata,
  output logic               rsp_err,
  output logic               ijtag_reset_n,
  output logic               ijtag_sel,
  output logic               ijtag_si,
  output logic               ijtag_ce,
  output logic               ijtag_se,
  output logic               ijtag_ue,
  input  logic               ijtag_so
);

  tdr_host_state_e  state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             cap_q, cap_d;
  logic             upd_q, upd_d;
  logic             err_q, err_d;
  logic             load, shift, last, si_next, len_ok;
  logic             sel_q, ce_q, se_q, ue_q, si_q, rst_n_q;

  assign len_ok = (req_len != '0) && (req_len <= LEN_W'(MAX_LEN));

  firebird7_in_gate1_tdr_host_shifter #(
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) u_shifter (
    .clk_i    (ijtag_tck),
    .rst_i    (ijtag_reset),
    .load_i   (load),
    .wdata_i  (req_wdata),
    .shift_i  (shift),
    .so_i     (ijtag_so),
    .len_i    (len_q),
    .last_o   (last),
    .si_next_o(si_next),
    .rdata_o  (rsp_rdata)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cap_d   = cap_q;
    upd_d   = upd_q;
    err_d   = err_q;
    load    = 1'b0;
    shift   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          load  = 1'b1;
          len_d = req_len;
          cap_d = req_capture;
          upd_d = req_update;
          err_d = !len_ok;
          if (!len_ok) begin
            state_d = StResp;
          end else if (req_capture) begin
            state_d = StCapture;
          end else begin
            state_d = StShift;
          end
        end
      end
      StCapture: state_d = StShift;
      StShift: begin
        shift = 1'b1;
        if (last) begin
          state_d = upd_q ? StUpdate : StResp;
        end
      end
      StUpdate: state_d = StResp;
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Strobes are decoded from the next state so they line up with the state they belong to.
  always_ff @(posedge ijtag_tck) begin
    if (ijtag_reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      cap_q   <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      sel_q   <= 1'b0;
      ce_q    <= 1'b0;
      se_q    <= 1'b0;
      ue_q    <= 1'b0;
      si_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cap_q   <= cap_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      sel_q   <= (state_d == StCapture) || (state_d == StShift) || (state_d == StUpdate);
      ce_q    <= (state_d == StCapture);
      se_q    <= (state_d == StShift);
      ue_q    <= (state_d == StUpdate);
      si_q    <= (state_d == StShift) && si_next;
    end
  end

  always_ff @(posedge ijtag_tck) begin
    rst_n_q <= ~ijtag_reset;
  end

  assign req_ready     = (state_q == StIdle);
  assign rsp_valid     = (state_q == StResp);
  assign rsp_err       = err_q;
  assign ijtag_reset_n = rst_n_q;
  assign ijtag_sel     = sel_q;
  assign ijtag_ce      = ce_q;
  assign ijtag_se      = se_q;
  assign ijtag_ue      = ue_q;
  assign ijtag_si      = si_q;

endmodule

// File: tb/tb_firebird7_in_gate1_tessent_tdr_host.sv
// Bench for the IJTAG TDR host against an 8-bit TDR client model.
module tb_firebird7_in_gate1_tessent_tdr_host;

  localparam int unsigned MaxLen = 32;
  localparam int unsigned LenW   = $clog2(MaxLen + 1);

  logic              ijtag_tck = 1'b0;
  logic              ijtag_reset = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic [LenW-1:0]   req_len = '0;
  logic              req_capture = 1'b0;
  logic              req_update = 1'b0;
  logic [MaxLen-1:0] req_wdata = '0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [MaxLen-1:0] rsp_rdata;
  logic              rsp_err;
  logic              ijtag_reset_n, ijtag_sel, ijtag_si, ijtag_ce, ijtag_se, ijtag_ue;
  logic              ijtag_so;

  firebird7_in_gate1_tessent_tdr_host #(
    .MAX_LEN(MaxLen),
    .LEN_W  (LenW)
  ) dut (
    .ijtag_tck    (ijtag_tck),
    .ijtag_reset  (ijtag_reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_len      (req_len),
    .req_capture  (req_capture),
    .req_update   (req_update),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .ijtag_reset_n(ijtag_reset_n),
    .ijtag_sel    (ijtag_sel),
    .ijtag_si     (ijtag_si),
    .ijtag_ce     (ijtag_ce),
    .ijtag_se     (ijtag_se),
    .ijtag_ue     (ijtag_ue),
    .ijtag_so     (ijtag_so)
  );

  always #5 ijtag_tck = ~ijtag_tck;

  // 8-bit tessent-style TDR client; scan out retimed on the low phase.
  logic [7:0] c_sr = '0;
  logic [7:0] c_upd = '0;
  logic       c_so = 1'b0;
  always @(posedge ijtag_tck) begin
    if (!ijtag_reset_n) begin
      c_sr  <= '0;
      c_upd <= '0;
    end else if (ijtag_sel) begin
      if (ijtag_ce)      c_sr  <= c_upd;
      else if (ijtag_se) c_sr  <= {ijtag_si, c_sr[7:1]};
      else if (ijtag_ue) c_upd <= c_sr;
    end
  end
  always @(negedge ijtag_tck) c_so <= c_sr[0];
  assign ijtag_so = c_so;

  int checks = 0;
  int errors = 0;
  int n_sel = 0, n_ce = 0, n_se = 0, n_ue = 0;
  int n_multi = 0, n_stray = 0;

  always @(posedge ijtag_tck) begin
    if (ijtag_sel) n_sel++;
    if (ijtag_ce)  n_ce++;
    if (ijtag_se)  n_se++;
    if (ijtag_ue)  n_ue++;
    if ((int'(ijtag_ce) + int'(ijtag_se) + int'(ijtag_ue)) > 1) n_multi++;
    if (!ijtag_sel && (ijtag_ce || ijtag_se || ijtag_ue || ijtag_si)) n_stray++;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ijtag_tck);
    #1;
  endtask

  // Reference: the client chain seen as a bit stream -- the 8 client bits come out
  // first, followed by the bits we push in.
  logic [7:0] m_sr = '0;
  logic [7:0] m_upd = '0;

  function automatic logic [31:0] model_apply(int len, bit cap, bit upd, logic [31:0] wdata);
    logic [63:0] stream;
    logic [63:0] mask;
    if (len < 1 || len > int'(MaxLen)) return 32'h0;
    if (cap) m_sr = m_upd;
    stream = ({32'h0, wdata} << 8) | {56'h0, m_sr};
    mask   = (64'd1 << len) - 64'd1;
    m_sr   = 8'((stream >> len) & 64'hFF);
    if (upd) m_upd = m_sr;
    return 32'(stream & mask);
  endfunction

  typedef struct {
    int          len;
    bit          cap;
    bit          upd;
    logic [31:0] wdata;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  task automatic exec(input vec_t v, input string tag);
    int          n;
    logic [31:0] held;
    bit          vld;
    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
    n_sel = 0; n_ce = 0; n_se = 0; n_ue = 0;
    req_len     = LenW'(v.len);
    req_capture = v.cap;
    req_update  = v.upd;
    req_wdata   = v.wdata;
    req_valid   = 1'b1;
    tick();
    req_valid = 1'b0;
    n = 1;
    while (!rsp_valid && n < 100) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd1);
    chk({tag, "_latency"}, 64'(n), 64'(v.exp_lat));
    chk({tag, "_rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    chk({tag, "_err"}, 64'(rsp_err), 64'(v.exp_err));
    held = rsp_rdata;
    for (int i = 0; i < v.hold; i++) begin
      tick();
      chk({tag, "_hold_valid"}, 64'(rsp_valid), 64'd1);
      chk({tag, "_hold_rdata"}, 64'(rsp_rdata), 64'(held));
      chk({tag, "_hold_req_ready"}, 64'(req_ready), 64'd0);
      chk({tag, "_hold_sel"}, 64'(ijtag_sel), 64'd0);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk({tag, "_ready_after"}, 64'(req_ready), 64'd1);
    chk({tag, "_valid_after"}, 64'(rsp_valid), 64'd0);
    vld = !v.exp_err;
    chk({tag, "_n_ce"}, 64'(n_ce), 64'(vld ? int'(v.cap) : 0));
    chk({tag, "_n_se"}, 64'(n_se), 64'(vld ? v.len : 0));
    chk({tag, "_n_ue"}, 64'(n_ue), 64'(vld ? int'(v.upd) : 0));
    chk({tag, "_n_sel"}, 64'(n_sel), 64'(vld ? v.len + int'(v.cap) + int'(v.upd) : 0));
  endtask

  function automatic vec_t model_vec(int len, bit cap, bit upd, logic [31:0] wdata, int hold);
    vec_t v;
    v.len       = len;
    v.cap       = cap;
    v.upd       = upd;
    v.wdata     = wdata;
    v.hold      = hold;
    v.exp_err   = (len < 1 || len > int'(MaxLen));
    v.exp_lat   = v.exp_err ? 1 : int'(cap) + len + int'(upd) + 1;
    v.exp_rdata = model_apply(len, cap, upd, wdata);
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[7];
    vec_t        v;
    logic [31:0] dummy;
    int          len;
    int          seen;

    tbl[0] = '{8,  1, 1, 32'hA5,       0, 32'h00,   0, 11};
    tbl[1] = '{8,  1, 1, 32'h3C,       0, 32'hA5,   0, 11};
    tbl[2] = '{0,  1, 1, 32'hFFFFFFFF, 0, 32'h0,    1, 1};
    tbl[3] = '{33, 0, 0, 32'h12345678, 0, 32'h0,    1, 1};
    tbl[4] = '{3,  0, 0, 32'h5,        5, 32'h4,    0, 4};
    tbl[5] = '{8,  0, 1, 32'hFF,       0, 32'hA7,   0, 10};
    tbl[6] = '{16, 1, 0, 32'h1234,     0, 32'h34FF, 0, 18};

    ijtag_reset = 1'b1;
    repeat (3) tick();
    chk("rst_req_ready", 64'(req_ready), 64'd1);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_strobes", 64'({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}), 64'd0);
    chk("rst_reset_n", 64'(ijtag_reset_n), 64'd0);
    ijtag_reset = 1'b0;
    tick();
    chk("rst_release_reset_n", 64'(ijtag_reset_n), 64'd1);

    for (int i = 0; i < 7; i++) begin
      exec(tbl[i], $sformatf("tbl%0d", i));
      dummy = model_apply(tbl[i].len, tbl[i].cap, tbl[i].upd, tbl[i].wdata);
    end

    for (int i = 0; i < 24; i++) begin
      if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : 33 + int'($urandom_range(0, 30));
      else len = int'($urandom_range(1, MaxLen));
      v = model_vec(len, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom,
                    int'($urandom_range(0, 2)));
      exec(v, $sformatf("rnd%0d", i));
    end

    // Abort a shift with reset while bit 4 is on the wire.
    req_len     = LenW'(8);
    req_capture = 1'b0;
    req_update  = 1'b0;
    req_wdata   = $urandom;
    req_valid   = 1'b1;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("abort_in_shift", 64'(ijtag_se), 64'd1);
    ijtag_reset = 1'b1;
    tick();
    chk("abort_idle", 64'(req_ready), 64'd1);
    chk("abort_strobes", 64'({ijtag_sel, ijtag_ce, ijtag_se, ijtag_ue, ijtag_si}), 64'd0);
    chk("abort_reset_n", 64'(ijtag_reset_n), 64'd0);
    chk("abort_no_valid", 64'(rsp_valid), 64'd0);
    repeat (2) tick();
    ijtag_reset = 1'b0;
    tick();
    chk("abort_release_reset_n", 64'(ijtag_reset_n), 64'd1);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid) seen++;
      tick();
    end
    chk("abort_no_rsp", 64'(seen), 64'd0);
    m_sr  = '0;
    m_upd = '0;
    exec(model_vec(8, 1'b1, 1'b0, 32'h5A, 0), "post_abort");
    exec(model_vec(32, 1'b0, 1'b1, 32'hDEADBEEF, 1), "post_abort_full");

    chk("strobe_exclusive", 64'(n_multi), 64'd0);
    chk("strobe_without_sel", 64'(n_stray), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/firebird7_in_gate1_tessent_tdr_host.md
# firebird7_in_gate1_tessent_tdr_host

IJTAG host-side access engine for the firebird7_in gate1 instrument network. It takes a parallel read/write request, drives the IJTAG client strobes (sel, si, ce, se, ue) through a Capture-Shift-Update sequence, and collects the serial return data from the client's scan output. It sits between the on-die register/test-access logic and a chain of tessent TDR clients such as the 8-bit spare-redundancy TDR, all clocked on `ijtag_tck`.

## Interface
- `MAX_LEN`, 32: maximum shift length in bits; sets the width of the data buses.
- `LEN_W`, $clog2(MAX_LEN+1): width of the length field.
- `ijtag_tck` input 1: the only clock; all flops are on its rising edge.
- `ijtag_reset` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: host idle and accepting a request.
- `req_len` input LEN_W: number of shift cycles, 1..MAX_LEN.
- `req_capture` input 1: 1 issues a capture cycle before shifting.
- `req_update` input 1: 1 issues an update cycle after shifting.
- `req_wdata` input MAX_LEN: shift-in data, LSB first.
- `rsp_valid` output 1: read data valid.
- `rsp_ready` input 1: response consumer ready.
- `rsp_rdata` output MAX_LEN: shift-out data, LSB first; zero above `req_len`.
- `rsp_err` output 1: request was rejected (`req_len` of 0 or greater than MAX_LEN).
- `ijtag_reset_n` output 1: client network reset, active-low.
- `ijtag_sel`, `ijtag_si`, `ijtag_ce`, `ijtag_se`, `ijtag_ue` output 1 each: client strobes.
- `ijtag_so` input 1: client scan output. The client retimes it on the low phase of `ijtag_tck`.

## Operation
- FSM states: IDLE, CAPTURE, SHIFT, UPDATE, RESP.
- IDLE: `req_ready`=1. When `req_valid` is high, latch `len`, `wdata` and the two flags, and clear `rdata`.
  - Invalid `req_len`: go directly to RESP with `rsp_err`=1 and `rsp_rdata`=0. No strobe is issued.
  - Otherwise go to CAPTURE if `req_capture`=1, else SHIFT.
- CAPTURE: one cycle with `sel`=1 and `ce`=1, then SHIFT.
- SHIFT: `len` cycles with `sel`=1 and `se`=1. `si` = `wdata[cnt]`.
  - Each rising edge: `rdata[cnt] <= ijtag_so`, then `cnt++`.
  - After the last bit, go to UPDATE if the flag is set, else RESP.
- UPDATE: one cycle with `sel`=1 and `ue`=1, then RESP.
- RESP: `rsp_valid`=1. Outputs are held stable until `rsp_ready` is high, then return to IDLE.
- Strobe rules:
  - `ce`, `se` and `ue` are mutually exclusive.
  - Outside CAPTURE, SHIFT and UPDATE, all strobes are 0 and `si`=0.
- `ijtag_reset_n` = ~`ijtag_reset`, registered. The client network resets together with the host.

## Timing
- Reset values:
  - State IDLE, `cnt`=0.
  - `req_ready`=1.
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0.
  - All strobes 0, `si`=0.
  - `ijtag_reset_n`=0 while reset is asserted, and 1 starting the cycle after it is released.
- Strobes and `si` are registered outputs, driven from state on the clock edge that enters that state.
- `ijtag_so` sampled at the end of shift cycle i equals client bit i, valid from the previous low phase.
- Latency from request acceptance to `rsp_valid`: `capture` + `len` + `update` + 1 cycles.
- Back-to-back requests: `req_ready` rises in the cycle after the RESP handshake. There is no overlap between requests.
- `rsp_valid` held with `rsp_ready`=0: all outputs are frozen and no strobe is issued.
- Reset asserted mid-SHIFT: on the next edge, return to IDLE, drop all strobes, and discard any partial `rdata`. No response is produced.

## Structure
- Package `firebird7_in_gate1_tdr_host_pkg`: holds the state enum `tdr_host_state_e` and the default `MAX_LEN`.
- Sub-module `firebird7_in_gate1_tdr_host_shifter`: contains `cnt`, `wdata` and `rdata`, plus the bit select and bit insert logic.
- The FSM and the handshakes stay in the top module.

## Test plan
- Reset, then a request with len=8, capture=1, update=1 and wdata=0xA5 against an 8-bit TDR client:
  - `rsp_rdata`=0x00.
  - `rsp_valid` 11 cycles after acceptance.
- Repeat with wdata=0x3C:
  - `rsp_rdata`=0xA5.
  - Exactly 8 `se` cycles, 1 `ce` cycle and 1 `ue` cycle.
- Request with len=0, then len=MAX_LEN+1:
  - `rsp_err`=1 and `rsp_rdata`=0 for both.
  - `sel` stays 0 throughout.
- Request with capture=0, update=0, len=3:
  - `ce` and `ue` are never asserted.
  - `rsp_valid` 4 cycles after acceptance.
- Hold `rsp_ready`=0 for 5 cycles:
  - `rsp_valid` and `rsp_rdata` stable, `req_ready`=0.
  - After `rsp_ready` rises, `req_ready`=1 the next cycle.
- Assert `ijtag_reset` during shift bit 4:
  - Next cycle: IDLE, strobes 0, `ijtag_reset_n`=0.
  - No `rsp_valid`.
